// File: rtl/ysyx_24100006_regfile_sb.sv
// ============================================================================
// ysyx_24100006_regfile_sb : multi-port register file with busy scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module ysyx_24100006_regfile_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_WR-1:0]            wen,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] waddr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wdata,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
  output logic [NUM_RD-1:0]            rbusy,
  input  logic                         issue_en,
  input  logic [ADDR_WIDTH-1:0]        issue_rd,
  output logic [ADDR_WIDTH:0]          busy_cnt
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rf [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_nxt;
  logic [ADDR_WIDTH:0]   cnt_nxt;

  // Ascending port loop: the last non-blocking write wins, so the highest port takes collisions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        rf[i] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wen[k] && (waddr[k*ADDR_WIDTH +: ADDR_WIDTH] != '0)) begin
          rf[waddr[k*ADDR_WIDTH +: ADDR_WIDTH]] <= wdata[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Clears first, then the issue set, so a new producer supersedes a same-cycle writeback.
  always_comb begin
    busy_nxt = busy;
    for (int k = 0; k < NUM_WR; k++) begin
      if (wen[k]) begin
        busy_nxt[waddr[k*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
      end
    end
    if (issue_en) begin
      busy_nxt[issue_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int r = 1; r < DEPTH; r++) begin
      cnt_nxt = cnt_nxt + {{ADDR_WIDTH{1'b0}}, busy_nxt[r]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  generate
    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
      logic [ADDR_WIDTH-1:0] ra;
      logic                  fwd;
      logic [DATA_WIDTH-1:0] fwd_data;

      assign ra = raddr[j*ADDR_WIDTH +: ADDR_WIDTH];

      always_comb begin
        fwd      = 1'b0;
        fwd_data = '0;
        if (BYPASS) begin
          for (int k = 0; k < NUM_WR; k++) begin
            if (wen[k] && (waddr[k*ADDR_WIDTH +: ADDR_WIDTH] == ra)) begin
              fwd      = 1'b1;
              fwd_data = wdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
      end

      always_comb begin
        if (ra == '0) begin
          rdata[j*DATA_WIDTH +: DATA_WIDTH] = '0;
          rbusy[j]                          = 1'b0;
        end else if (fwd) begin
          rdata[j*DATA_WIDTH +: DATA_WIDTH] = fwd_data;
          rbusy[j]                          = 1'b0;
        end else begin
          rdata[j*DATA_WIDTH +: DATA_WIDTH] = rf[ra];
          rbusy[j]                          = busy[ra];
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_ysyx_24100006_regfile_sb.sv
// ============================================================================
// tb_ysyx_24100006_regfile_sb : scoreboard bench for two regfile configurations
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_24100006_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  // main instance: 2 read, 2 write ports, bypass on
  logic [1:0]  m_wen;
  logic [9:0]  m_waddr;
  logic [63:0] m_wdata;
  logic [9:0]  m_raddr;
  logic [63:0] m_rdata;
  logic [1:0]  m_rbusy;
  logic        m_issue_en;
  logic [4:0]  m_issue_rd;
  logic [5:0]  m_busy_cnt;

  // alternate instance: 1 read, 1 write port, bypass off
  logic        a_wen;
  logic [4:0]  a_waddr;
  logic [31:0] a_wdata;
  logic [4:0]  a_raddr;
  logic [31:0] a_rdata;
  logic        a_rbusy;
  logic        a_issue_en;
  logic [4:0]  a_issue_rd;
  logic [5:0]  a_busy_cnt;

  ysyx_24100006_regfile_sb #(
    .ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1'b1)
  ) dut_m (
    .clk(clk), .rst_n(rst_n), .wen(m_wen), .waddr(m_waddr), .wdata(m_wdata),
    .raddr(m_raddr), .rdata(m_rdata), .rbusy(m_rbusy),
    .issue_en(m_issue_en), .issue_rd(m_issue_rd), .busy_cnt(m_busy_cnt)
  );

  ysyx_24100006_regfile_sb #(
    .ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(1), .NUM_WR(1), .BYPASS(1'b0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .wen(a_wen), .waddr(a_waddr), .wdata(a_wdata),
    .raddr(a_raddr), .rdata(a_rdata), .rbusy(a_rbusy),
    .issue_en(a_issue_en), .issue_rd(a_issue_rd), .busy_cnt(a_busy_cnt)
  );

  always #5 clk = ~clk;

  localparam int M_RD0 = 0, M_RD1 = 1, M_BZ0 = 2, M_BZ1 = 3, M_CNT = 4;
  localparam int A_RD = 5, A_BZ = 6, A_CNT = 7;

  typedef struct {
    string       tag;
    int          what;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] observe(input int what);
    case (what)
      M_RD0:   observe = m_rdata[31:0];
      M_RD1:   observe = m_rdata[63:32];
      M_BZ0:   observe = {31'b0, m_rbusy[0]};
      M_BZ1:   observe = {31'b0, m_rbusy[1]};
      M_CNT:   observe = {26'b0, m_busy_cnt};
      A_RD:    observe = a_rdata;
      A_BZ:    observe = {31'b0, a_rbusy};
      default: observe = {26'b0, a_busy_cnt};
    endcase
  endfunction

  task automatic expect_val(input string tag, input int what, input logic [31:0] exp);
    exp_t e;
    e.tag  = tag;
    e.what = what;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  // settle one time unit after the inputs change, then compare everything queued
  task automatic drain();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.what), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    m_wen = '0; m_waddr = '0; m_wdata = '0; m_issue_en = 1'b0; m_issue_rd = '0;
    a_wen = 1'b0; a_waddr = '0; a_wdata = '0; a_issue_en = 1'b0; a_issue_rd = '0;
  endtask

  task automatic m_write(input int port, input int addr, input logic [31:0] data);
    m_wen[port]             = 1'b1;
    m_waddr[port*5 +: 5]    = 5'(addr);
    m_wdata[port*32 +: 32]  = data;
  endtask

  function automatic logic [31:0] pat(input int r);
    pat = 32'hC0DE_0000 ^ (32'(r) * 32'h0101_0101);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    m_raddr = '0;
    a_raddr = '0;
    #2 rst_n = 1'b0;
    @(negedge clk);

    // reset held while a write is presented: nothing lands
    m_write(0, 5, 32'h0000_DEAD);
    a_wen = 1'b1; a_waddr = 5'd5; a_wdata = 32'h0000_DEAD; a_raddr = 5'd5;
    repeat (3) tick();
    expect_val("rst_a_rdata", A_RD, 32'h0);
    expect_val("rst_m_cnt", M_CNT, 32'h0);
    expect_val("rst_a_cnt", A_CNT, 32'h0);
    drain();
    idle();
    m_raddr[4:0] = 5'd5;
    expect_val("rst_m_rdata", M_RD0, 32'h0);
    drain();
    rst_n = 1'b1;
    tick();
    expect_val("post_rst_m_rdata", M_RD0, 32'h0);
    expect_val("post_rst_a_rdata", A_RD, 32'h0);
    drain();

    // x0: writes and issues to register 0 are ignored
    m_write(0, 0, 32'hFFFF_FFFF);
    m_raddr[4:0] = 5'd0;
    m_issue_en = 1'b1; m_issue_rd = 5'd0;
    expect_val("x0_rdata_byp", M_RD0, 32'h0);
    expect_val("x0_rbusy_byp", M_BZ0, 32'h0);
    drain();
    tick();
    idle();
    expect_val("x0_rdata", M_RD0, 32'h0);
    expect_val("x0_cnt", M_CNT, 32'h0);
    drain();

    // bypass vs no bypass
    m_write(0, 3, 32'h0000_1234);
    m_raddr[4:0] = 5'd3;
    a_wen = 1'b1; a_waddr = 5'd3; a_wdata = 32'h0000_1234; a_raddr = 5'd3;
    expect_val("byp_m_same_cycle", M_RD0, 32'h0000_1234);
    expect_val("nobyp_a_same_cycle", A_RD, 32'h0);
    drain();
    tick();
    idle();
    expect_val("byp_m_after", M_RD0, 32'h0000_1234);
    expect_val("nobyp_a_after", A_RD, 32'h0000_1234);
    drain();

    // scoreboard issue then writeback on reg 7
    m_issue_en = 1'b1; m_issue_rd = 5'd7; m_raddr[4:0] = 5'd7;
    a_issue_en = 1'b1; a_issue_rd = 5'd7; a_raddr = 5'd7;
    expect_val("sb_pre_issue_rbusy", M_BZ0, 32'h0);
    drain();
    tick();
    idle();
    expect_val("sb_m_rbusy", M_BZ0, 32'h1);
    expect_val("sb_m_cnt1", M_CNT, 32'h1);
    expect_val("sb_a_rbusy", A_BZ, 32'h1);
    expect_val("sb_a_cnt1", A_CNT, 32'h1);
    drain();
    m_write(0, 7, 32'h0000_0077);
    a_wen = 1'b1; a_waddr = 5'd7; a_wdata = 32'h0000_0077;
    expect_val("wb_m_rbusy_fwd", M_BZ0, 32'h0);
    expect_val("wb_m_rdata_fwd", M_RD0, 32'h0000_0077);
    expect_val("wb_a_rbusy_nofwd", A_BZ, 32'h1);
    drain();
    tick();
    idle();
    expect_val("wb_m_cnt0", M_CNT, 32'h0);
    expect_val("wb_m_rbusy", M_BZ0, 32'h0);
    expect_val("wb_a_cnt0", A_CNT, 32'h0);
    expect_val("wb_a_rbusy", A_BZ, 32'h0);
    drain();

    // issue and writeback on the same edge for an already busy reg 9
    m_issue_en = 1'b1; m_issue_rd = 5'd9;
    tick();
    idle();
    m_issue_en = 1'b1; m_issue_rd = 5'd9;
    m_write(1, 9, 32'h0000_0099);
    m_raddr[9:5] = 5'd9;
    expect_val("iw_rbusy_fwd", M_BZ1, 32'h0);
    expect_val("iw_rdata_fwd", M_RD1, 32'h0000_0099);
    expect_val("iw_cnt_pre", M_CNT, 32'h1);
    drain();
    tick();
    idle();
    expect_val("iw_rbusy_kept", M_BZ1, 32'h1);
    expect_val("iw_cnt_kept", M_CNT, 32'h1);
    expect_val("iw_rdata", M_RD1, 32'h0000_0099);
    drain();

    // writeback to a non-busy register alongside a new issue
    m_issue_en = 1'b1; m_issue_rd = 5'd10;
    m_write(0, 11, 32'h0000_0011);
    tick();
    idle();
    m_raddr[4:0] = 5'd11;
    expect_val("nb_rdata", M_RD0, 32'h0000_0011);
    expect_val("nb_rbusy", M_BZ0, 32'h0);
    expect_val("nb_cnt2", M_CNT, 32'h2);
    drain();

    // write collision: highest port wins
    m_write(0, 4, 32'h0000_AAAA);
    m_write(1, 4, 32'h0000_BBBB);
    m_raddr[4:0] = 5'd4;
    expect_val("coll_fwd", M_RD0, 32'h0000_BBBB);
    drain();
    tick();
    idle();
    expect_val("coll_stored", M_RD0, 32'h0000_BBBB);
    drain();

    // fill every register, alternating ports, then read back on both ports
    for (int r = 1; r < 32; r++) begin
      m_write(r % 2, r, pat(r));
      tick();
      idle();
    end
    for (int r = 1; r < 32; r++) begin
      m_raddr[4:0] = 5'(r);
      m_raddr[9:5] = 5'((r % 31) + 1);
      expect_val($sformatf("fill_rd0_r%0d", r), M_RD0, pat(r));
      expect_val($sformatf("fill_rd1_r%0d", r), M_RD1, pat((r % 31) + 1));
      drain();
    end
    expect_val("fill_cnt0", M_CNT, 32'h0);
    drain();

    // mark every register busy, including a redundant issue of x0
    for (int r = 0; r < 32; r++) begin
      m_issue_en = 1'b1; m_issue_rd = 5'(r);
      tick();
    end
    idle();
    m_raddr[4:0] = 5'd20;
    expect_val("full_cnt31", M_CNT, 32'd31);
    expect_val("full_rbusy20", M_BZ0, 32'h1);
    drain();

    // asynchronous reset mid-cycle, checked before the next rising edge
    #2 rst_n = 1'b0;
    expect_val("async_cnt", M_CNT, 32'h0);
    expect_val("async_rbusy", M_BZ0, 32'h0);
    expect_val("async_rdata", M_RD0, 32'h0);
    expect_val("async_a_rdata", A_RD, 32'h0);
    drain();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    expect_val("after_async_cnt", M_CNT, 32'h0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
